// File: rtl/parity_frame_sched_if.sv
// Bundle of requester streams, result channel and status for parity_frame_sched.
// master: the client side (stream sources + result consumer); slave: the scheduler.
interface parity_frame_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int CNTW = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;

    logic              res_valid;
    logic              res_ready;
    logic              res_parity;
    logic [IDW-1:0]    res_id;
    logic [CNTW-1:0]   res_len;

    logic              busy;

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_parity, res_id, res_len, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_parity, res_id, res_len, busy
    );
endinterface

// File: rtl/parity_frame_sched.sv
// parity_frame_sched: one shared XOR-reduction datapath, round-robin arbitrated
// among NREQ frame streams. The grant is locked for a whole frame and one result
// (parity, owner id, saturating word count) is returned per frame.
// Build option: define PARITY_FRAME_ODD_EN for odd parity (inverted frame XOR);
// default build reports even parity.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no frame owned; round-robin search for the next requester
// ST_BUSY | grant locked, accepting words from the granted requester only
// ST_RESP | result presented, waiting for the consumer to take it
module parity_frame_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_frame_sched_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

`ifdef PARITY_FRAME_ODD_EN
    localparam logic PAR_INV = 1'b1;
`else
    localparam logic PAR_INV = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   rr_next;

    logic             arb_found;
    logic [IDW-1:0]   arb_idx;
    int               cand;
    logic [IDW-1:0]   cand_idx;

    logic             gnt_valid;
    logic             gnt_last;
    logic [W-1:0]     gnt_data;
    logic             hs;

    logic             acc_q;
    logic             acc_nxt;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  cnt_nxt;

    logic             res_parity_q;
    logic [IDW-1:0]   res_id_q;
    logic [CNTW-1:0]  res_len_q;

    // Round-robin search: first valid requester at or above rr_q, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!arb_found && bus.req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Select the granted requester's stream; everything else is ignored.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                gnt_valid = bus.req_valid[i];
                gnt_last  = bus.req_last[i];
                gnt_data  = bus.req_data[i*W +: W];
            end
        end
    end

    // Only the granted requester sees ready, and only while a frame is open.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_q == ST_BUSY) && (grant_q == IDW'(i))) begin
                bus.req_ready[i] = 1'b1;
            end
        end
    end

    assign hs      = (state_q == ST_BUSY) && gnt_valid;
    assign acc_nxt = acc_q ^ (^gnt_data);
    assign cnt_nxt = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign rr_next = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    // Next-state logic; the grant moves only when leaving IDLE, rr only on result pop.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (hs && gnt_last) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    rr_d    = rr_next;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // Frame accumulator and saturating word counter; cleared when a grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && arb_found) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else if (hs) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Result capture on the last-word handshake, from the already-updated values,
    // so the result holds steady through RESP regardless of the stream inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_parity_q <= 1'b0;
            res_id_q     <= '0;
            res_len_q    <= '0;
        end else if (hs && gnt_last) begin
            res_parity_q <= acc_nxt ^ PAR_INV;
            res_id_q     <= grant_q;
            res_len_q    <= cnt_nxt;
        end
    end

    assign bus.res_valid  = (state_q == ST_RESP);
    assign bus.res_parity = res_parity_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_len    = res_len_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_frame_sched.sv
// Directed bench for parity_frame_sched: two instances share one stimulus, one with
// the default 8-bit counter and one with a 2-bit counter to expose saturation.
module tb_parity_frame_sched;
    localparam int NREQ = 4;
    localparam int W    = 4;

`ifdef PARITY_FRAME_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_last;
    logic [W-1:0]    wd [NREQ];
    logic            res_ready;

    int n_vec;
    int n_err;

    logic [3:0] w5 [5];

    parity_frame_sched_if #(.NREQ(NREQ), .W(W), .CNTW(8)) if_a ();
    parity_frame_sched_if #(.NREQ(NREQ), .W(W), .CNTW(2)) if_b ();

    assign if_a.req_valid = req_valid;
    assign if_a.req_last  = req_last;
    assign if_a.req_data  = {wd[3], wd[2], wd[1], wd[0]};
    assign if_a.res_ready = res_ready;
    assign if_b.req_valid = req_valid;
    assign if_b.req_last  = req_last;
    assign if_b.req_data  = {wd[3], wd[2], wd[1], wd[0]};
    assign if_b.res_ready = res_ready;

    parity_frame_sched #(.NREQ(NREQ), .W(W), .CNTW(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    parity_frame_sched #(.NREQ(NREQ), .W(W), .CNTW(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic par, input logic [1:0] id,
                           input logic [7:0] len);
        chk({tag, "_valid"}, 32'(if_a.res_valid), 32'd1);
        chk({tag, "_parity"}, 32'(if_a.res_parity), 32'(par ^ ODD));
        chk({tag, "_id"}, 32'(if_a.res_id), 32'(id));
        chk({tag, "_len"}, 32'(if_a.res_len), 32'(len));
        chk({tag, "_ready"}, 32'(if_a.req_ready), 32'd0);
    endtask

    task automatic pop_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) wd[i] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        w5[0] = 4'h1; w5[1] = 4'h2; w5[2] = 4'h7; w5[3] = 4'hF; w5[4] = 4'h3;

        // reset values
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) wd[i] = '0;
        tick();
        chk("rst_busy", 32'(if_a.busy), 32'd0);
        chk("rst_ready", 32'(if_a.req_ready), 32'd0);
        chk("rst_res_valid", 32'(if_a.res_valid), 32'd0);
        chk("rst_parity", 32'(if_a.res_parity), 32'd0);
        chk("rst_id", 32'(if_a.res_id), 32'd0);
        chk("rst_len", 32'(if_a.res_len), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: req0 frame A,7,1(last) -> parity 0, id 0, len 3
        req_valid = 4'b0001;
        wd[0]     = 4'hA;
        chk("t1_idle_ready", 32'(if_a.req_ready), 32'd0);
        tick();
        chk("t1_grant_ready", 32'(if_a.req_ready), 32'b0001);
        chk("t1_busy", 32'(if_a.busy), 32'd1);
        tick();
        wd[0] = 4'h7;
        tick();
        wd[0] = 4'h1;
        req_last[0] = 1'b1;
        tick();
        req_valid = '0;
        req_last  = '0;
        chk_res("t1", 1'b0, 2'd0, 8'd3);
        pop_res();
        chk("t1_pop_valid", 32'(if_a.res_valid), 32'd0);
        chk("t1_pop_busy", 32'(if_a.busy), 32'd0);

        // 2: req1 and req3 together with rr=0 -> req1, then req3, rr wraps to 0
        do_reset();
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        wd[1] = 4'h3;
        wd[3] = 4'hB;
        tick();
        chk("t2_grant1", 32'(if_a.req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        chk_res("t2a", 1'b0, 2'd1, 8'd1);
        pop_res();
        chk("t2_idle_ready", 32'(if_a.req_ready), 32'd0);
        tick();
        chk("t2_grant3", 32'(if_a.req_ready), 32'b1000);
        tick();
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        wd[0] = 4'h1;
        wd[2] = 4'h8;
        chk_res("t2b", 1'b1, 2'd3, 8'd1);
        pop_res();
        tick();
        chk("t2_wrap_grant0", 32'(if_a.req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        chk_res("t2c", 1'b1, 2'd0, 8'd1);
        pop_res();

        // 3: req2 one word 8, consumer stalls 5 cycles while req0 keeps asking
        tick();
        chk("t3_grant2", 32'(if_a.req_ready), 32'b0100);
        tick();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            chk_res("t3_hold", 1'b1, 2'd2, 8'd1);
            tick();
        end
        req_valid = '0;
        pop_res();

        // 4: req1 granted (rr=3), its valid drops 3 cycles while req0 waits
        req_valid = 4'b0010;
        wd[1] = 4'h1;
        tick();
        chk("t4_grant1", 32'(if_a.req_ready), 32'b0010);
        tick();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        wd[0] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_stall_ready", 32'(if_a.req_ready), 32'b0010);
            chk("t4_stall_valid", 32'(if_a.res_valid), 32'd0);
        end
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        wd[1] = 4'h3;
        tick();
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        chk_res("t4a", 1'b1, 2'd1, 8'd2);
        pop_res();
        tick();
        chk("t4_grant0", 32'(if_a.req_ready), 32'b0001);
        tick();
        req_valid = '0;
        req_last  = '0;
        chk_res("t4b", 1'b0, 2'd0, 8'd1);
        pop_res();

        // 5: 5-word frame; 2-bit counter saturates at 3, 8-bit counter reads 5
        req_valid = 4'b0001;
        wd[0] = w5[0];
        tick();
        for (int k = 0; k < 5; k++) begin
            wd[0]       = w5[k];
            req_last[0] = (k == 4);
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        chk_res("t5a", 1'b1, 2'd0, 8'd5);
        chk("t5b_valid", 32'(if_b.res_valid), 32'd1);
        chk("t5b_len_sat", 32'(if_b.res_len), 32'd3);
        chk("t5b_parity", 32'(if_b.res_parity), 32'(1'b1 ^ ODD));
        pop_res();

        // 6: reset mid-frame, no result, then a clean frame
        req_valid = 4'b0100;
        wd[2] = 4'h5;
        tick();
        chk("t6_grant2", 32'(if_a.req_ready), 32'b0100);
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("t6_rst_busy", 32'(if_a.busy), 32'd0);
        chk("t6_rst_ready", 32'(if_a.req_ready), 32'd0);
        chk("t6_rst_valid", 32'(if_a.res_valid), 32'd0);
        chk("t6_rst_parity", 32'(if_a.res_parity), 32'd0);
        chk("t6_rst_len", 32'(if_a.res_len), 32'd0);
        tick();
        chk("t6_rst_valid2", 32'(if_a.res_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_post_valid", 32'(if_a.res_valid), 32'd0);
        chk("t6_post_busy", 32'(if_a.busy), 32'd0);
        req_valid = 4'b0100;
        wd[2] = 4'h6;
        tick();
        chk("t6_regrant2", 32'(if_a.req_ready), 32'b0100);
        tick();
        wd[2] = 4'h4;
        req_last[2] = 1'b1;
        tick();
        req_valid = '0;
        req_last  = '0;
        chk_res("t6", 1'b1, 2'd2, 8'd2);
        pop_res();
        chk("t6_end_busy", 32'(if_a.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
